alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single combinational alu (operand_a/operand_b/alu_op -> alu_result/zero_flag) between two requesters.
//  Port 0 is the execute stage; port 1 is the ALU self-check/debug engine.
//  Arbitrates round-robin, registers operands, runs one ALU evaluation and returns a registered result.
//  Each port uses a valid/ready handshake. Sits beside the EX stage; the alu instance is external.
// PARAMETERS
//  XLEN        32  operand/result width
//  OPW         4   alu_op width (matches `ALU_* codes in defines.v)
//  CNTW        16  width of completed-operation counter
//  FIXED_PRI   0   0 = round-robin; 1 = port 0 always wins ties
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  req_valid      in   2       per-port request valid (bit i = port i)
//  req_ready      out  2       per-port request accept
//  req_a0/req_a1  in   XLEN    port 0/1 operand A
//  req_b0/req_b1  in   XLEN    port 0/1 operand B
//  req_op0/req_op1 in  OPW     port 0/1 ALU op code
//  rsp_valid      out  2       per-port response valid
//  rsp_ready      in   2       per-port response accept
//  rsp_result     out  XLEN    registered result (valid for granted port only)
//  rsp_zero       out  1       registered zero flag
//  alu_a/alu_b    out  XLEN    to alu operand_a/operand_b
//  alu_opcode     out  OPW     to alu alu_op
//  alu_res        in   XLEN    from alu alu_result
//  alu_zero       in   1       from alu zero_flag
//  busy           out  1       high in EXEC or RESP
//  ops_done       out  CNTW    count of completed responses, wraps
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, alu_a/b/opcode=0.
//   Also under reset: ops_done=0, gnt=0, last_gnt=1 (port 0 wins the first tie).
//  FSM IDLE -> EXEC -> RESP -> IDLE. One operation in flight; max throughput one per 3 cycles.
//  IDLE: req_ready[i] = 1 only for the port selected this cycle; the selected port is defined as follows.
//   If only one port's req_valid is set, that port is selected.
//   On a tie with FIXED_PRI=0, the port != last_gnt is selected; with FIXED_PRI=1, port 0 is selected.
//   On handshake (valid&ready), latch a/b/op of the winner and set gnt and last_gnt. Go to EXEC.
//   req_ready is combinational from state and req_valid; it is never high outside IDLE.
//  EXEC: alu_a/b/opcode driven from latched registers (held at 0 in other states).
//   alu_res/alu_zero captured into rsp_result/rsp_zero at end of cycle. Go to RESP.
//  RESP: rsp_valid[gnt]=1; the other bit is 0. Result is held stable until rsp_ready[gnt]=1.
//   On handshake: ops_done+1 (wraps at 2^CNTW-1 -> 0), next state IDLE, rsp_valid cleared next cycle.
//   rsp_ready of the non-granted port is ignored.
//  Latency: request accepted in cycle T -> rsp_valid high in cycle T+2.
//  A new request valid during EXEC/RESP waits. Requesters must hold valid and payload until ready.
//  Arithmetic is entirely in the alu; this block adds no width changes. Results wrap mod 2^XLEN as the alu gives them.
//  Reset mid-operation: the in-flight op is dropped with no response and ops_done is cleared.
//   The next cycle is IDLE with reset values.
//  Unknown op codes are passed through to the alu unchanged.
// TESTING
//  1 Single SUB: port0 a=0x401e1042 b=0x7fffffff op=`ALU_SUB at T.
//    -> req_ready[0]=1 at T; rsp_valid[0] at T+2; rsp_result=0xc01e1043, rsp_zero=0.
//  2 Zero flag: port1 a=b=0xc41f1efb `ALU_SUB -> rsp_valid[1], rsp_result=0, rsp_zero=1.
//    Also port1 a=0xc41f1efb b=0xec66e522 `ALU_SUB -> rsp_result=0xd7b839d9.
//  3 Round-robin: both ports valid continuously after reset -> grants 0,1,0,1.
//    Each response routes to the correct port; ops_done=4 after four responses.
//    With FIXED_PRI=1 -> grants 0,0,0,0.
//  4 Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid/result stable, req_ready=0 on both ports.
//    Completion occurs on the cycle rsp_ready rises.
//  5 Reset mid-op: assert rst in EXEC -> next cycle all outputs at reset values, no rsp_valid.
//    The following request behaves as in scenario 1.
//  6 Counter wrap: CNTW=2, five completions -> ops_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response handshake bundle between two requesters and the ALU share arbiter
//   req_valid/req_ready  per-port request handshake (bit i = port i)
//   req_a*/req_b*/req_op* per-port operands and op code
//   rsp_valid/rsp_ready  per-port response handshake
//   rsp_result/rsp_zero  registered ALU result and zero flag for the granted port
interface alu_share_arbiter_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req_a0;
    logic [XLEN-1:0] req_a1;
    logic [XLEN-1:0] req_b0;
    logic [XLEN-1:0] req_b1;
    logic [OPW-1:0]  req_op0;
    logic [OPW-1:0]  req_op1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters (round-robin or fixed priority)
//   clk, rst         clock and synchronous active-high reset
//   bus              request/response handshakes for ports 0 and 1 (slave side)
//   alu_a/alu_b      operands to the external ALU, zero outside EXEC
//   alu_opcode       op code to the external ALU, zero outside EXEC
//   alu_res/alu_zero result and zero flag from the external ALU
//   busy             high while an operation is in EXEC or RESP
//   ops_done         wrapping count of completed responses
module alu_share_arbiter #(
    parameter int XLEN      = 32,
    parameter int OPW       = 4,
    parameter int CNTW      = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [OPW-1:0]       alu_opcode,
    input  logic [XLEN-1:0]      alu_res,
    input  logic                 alu_zero,
    output logic                 busy,
    output logic [CNTW-1:0]      ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t          state, state_n;
    logic            sel, acc, done, gnt, last_gnt;
    logic [XLEN-1:0] a_q, b_q;
    logic [OPW-1:0]  op_q;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // On a tie the round-robin pick is the port that did not win last time.
    always_comb begin
        sel     = &bus.req_valid ? (FIXED_PRI ? 1'b0 : ~last_gnt) : bus.req_valid[1];
        acc     = state == IDLE && |bus.req_valid;
        done    = state == RESP && bus.rsp_ready[gnt];
        state_n = state == IDLE ? (acc ? EXEC : IDLE) :
                  state == EXEC ? RESP : (done ? IDLE : RESP);
    end

    always_comb begin
        bus.req_ready = {sel, ~sel} & {2{acc}};
        bus.rsp_valid = {gnt, ~gnt} & {2{state == RESP}};
        alu_a         = state == EXEC ? a_q : '0;
        alu_b         = state == EXEC ? b_q : '0;
        alu_opcode    = state == EXEC ? op_q : '0;
        busy          = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            gnt            <= 1'b0;
            last_gnt       <= 1'b1;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            ops_done       <= '0;
        end else begin
            if (acc) begin
                a_q      <= sel ? bus.req_a1 : bus.req_a0;
                b_q      <= sel ? bus.req_b1 : bus.req_b0;
                op_q     <= sel ? bus.req_op1 : bus.req_op0;
                gnt      <= sel;
                last_gnt <= sel;
            end
            if (state == EXEC) begin
                bus.rsp_result <= alu_res;
                bus.rsp_zero   <= alu_zero;
            end
            if (done)
                ops_done <= ops_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the ALU share arbiter with a stand-in ALU on each instance
module tb_alu_share_arbiter;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    alu_share_arbiter_if #(.XLEN(32), .OPW(4)) bus0();
    alu_share_arbiter_if #(.XLEN(32), .OPW(4)) bus1();

    logic [31:0] a0, b0, r0, a1, b1, r1;
    logic [3:0]  o0, o1;
    logic        z0, z1, busy0, busy1;
    logic [15:0] done0;
    logic [1:0]  done1;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return op == ALU_SUB ? a - b : op == ALU_ADD ? a + b : a ^ b;
    endfunction

    assign r0 = alu_f(o0, a0, b0);
    assign z0 = r0 == 32'd0;
    assign r1 = alu_f(o1, a1, b1);
    assign z1 = r1 == 32'd0;

    alu_share_arbiter #(.XLEN(32), .OPW(4), .CNTW(16), .FIXED_PRI(1'b0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0), .alu_a(a0), .alu_b(b0), .alu_opcode(o0),
        .alu_res(r0), .alu_zero(z0), .busy(busy0), .ops_done(done0)
    );

    alu_share_arbiter #(.XLEN(32), .OPW(4), .CNTW(2), .FIXED_PRI(1'b1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .alu_a(a1), .alu_b(b1), .alu_opcode(o1),
        .alu_res(r1), .alu_zero(z1), .busy(busy1), .ops_done(done1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        bus0.req_valid = p == 1 ? 2'b10 : 2'b01;
        if (p == 1) begin
            bus0.req_a1 = a; bus0.req_b1 = b; bus0.req_op1 = op;
        end else begin
            bus0.req_a0 = a; bus0.req_b0 = b; bus0.req_op0 = op;
        end
        #1 check("req_ready_idle", bus0.req_ready, p == 1 ? 2'b10 : 2'b01);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 2'b00;
        #1 check("busy_exec", busy0, 1'b1);
        check("alu_a_exec", a0, a);
        check("alu_op_exec", o0, op);
        check("req_ready_exec", bus0.req_ready, 2'b00);
    endtask

    task automatic rsp(input int p, input logic [31:0] res, input logic z);
        @(negedge clk);
        check("rsp_valid", bus0.rsp_valid, p == 1 ? 2'b10 : 2'b01);
        check("rsp_result", bus0.rsp_result, res);
        check("rsp_zero", bus0.rsp_zero, z);
    endtask

    initial begin
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus0.req_valid = '0; bus0.req_a0 = '0; bus0.req_a1 = '0; bus0.req_b0 = '0; bus0.req_b1 = '0;
        bus0.req_op0 = '0; bus0.req_op1 = '0; bus0.rsp_ready = 2'b11;
        bus1.req_valid = '0; bus1.req_a0 = '0; bus1.req_a1 = '0; bus1.req_b0 = '0; bus1.req_b1 = '0;
        bus1.req_op0 = '0; bus1.req_op1 = '0; bus1.rsp_ready = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus0.req_ready, 2'b00);
        check("rst_rsp_valid", bus0.rsp_valid, 2'b00);
        check("rst_rsp_result", bus0.rsp_result, 32'd0);
        check("rst_rsp_zero", bus0.rsp_zero, 1'b0);
        check("rst_alu_a", a0, 32'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_ops_done", done0, 16'd0);
        rst = 1'b0;

        req(0, 32'h401e1042, 32'h7fffffff, ALU_SUB);
        rsp(0, 32'hc01e1043, 1'b0);
        @(negedge clk);
        check("s1_ops_done", done0, 16'd1);
        check("s1_rsp_cleared", bus0.rsp_valid, 2'b00);

        req(1, 32'hc41f1efb, 32'hc41f1efb, ALU_SUB);
        rsp(1, 32'h00000000, 1'b1);
        req(1, 32'hc41f1efb, 32'hec66e522, ALU_SUB);
        rsp(1, 32'hd7b839d9, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s3_ops_reset", done0, 16'd0);
        bus0.req_a0 = 32'd10; bus0.req_b0 = 32'd3; bus0.req_op0 = ALU_ADD;
        bus0.req_a1 = 32'd10; bus0.req_b1 = 32'd3; bus0.req_op1 = ALU_SUB;
        bus0.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_grant", bus0.req_ready, i % 2 == 1 ? 2'b10 : 2'b01);
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp_valid", bus0.rsp_valid, i % 2 == 1 ? 2'b10 : 2'b01);
            check("rr_rsp_result", bus0.rsp_result, i % 2 == 1 ? 32'd7 : 32'd13);
            @(negedge clk);
        end
        bus0.req_valid = 2'b00;
        check("rr_ops_done", done0, 16'd4);

        bus0.rsp_ready = 2'b10;
        req(0, 32'h401e1042, 32'h7fffffff, ALU_SUB);
        rsp(0, 32'hc01e1043, 1'b0);
        bus0.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_rsp_valid", bus0.rsp_valid, 2'b01);
            check("bp_rsp_result", bus0.rsp_result, 32'hc01e1043);
            check("bp_req_ready", bus0.req_ready, 2'b00);
            check("bp_ops_hold", done0, 16'd4);
            @(negedge clk);
        end
        bus0.rsp_ready = 2'b01;
        @(negedge clk);
        #1 check("bp_ops_done", done0, 16'd5);
        check("bp_rsp_cleared", bus0.rsp_valid, 2'b00);
        check("bp_next_grant", bus0.req_ready, 2'b10);
        bus0.req_valid = 2'b00;
        bus0.rsp_ready = 2'b11;

        req(0, 32'd5, 32'd3, ALU_SUB);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", bus0.rsp_valid, 2'b00);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_alu_a", a0, 32'd0);
        check("mid_rst_rsp_result", bus0.rsp_result, 32'd0);
        check("mid_rst_ops_done", done0, 16'd0);
        check("mid_rst_req_ready", bus0.req_ready, 2'b00);
        rst = 1'b0;
        req(0, 32'h401e1042, 32'h7fffffff, ALU_SUB);
        rsp(0, 32'hc01e1043, 1'b0);
        @(negedge clk);
        check("mid_rst_ops_after", done0, 16'd1);

        bus1.req_a0 = 32'd1; bus1.req_b0 = 32'd1; bus1.req_op0 = ALU_ADD;
        bus1.req_a1 = 32'd9; bus1.req_b1 = 32'd4; bus1.req_op1 = ALU_SUB;
        bus1.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1 check("fp_grant", bus1.req_ready, 2'b01);
            @(negedge clk);
            @(negedge clk);
            check("fp_rsp_valid", bus1.rsp_valid, 2'b01);
            check("fp_rsp_result", bus1.rsp_result, 32'd2);
            @(negedge clk);
            check("wrap_ops_done", done1, exp_cnt[i]);
        end
        bus1.req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
